// File: rtl/morse_rx_decoder.sv
// Morse receiver: times mark/space runs on a synchronized line, assembles up to
// four dot/dash symbols and decodes them to the 3-bit letter code A..H.
module morse_rx_decoder #(
    parameter int unsigned UNIT_CYCLES = 250,
    parameter int unsigned CNT_W       = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dot_dash_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       decode_error,
    output logic       busy
);

    localparam int unsigned SYM_W = 3;
    localparam int unsigned PAT_W = 4;

    localparam logic [CNT_W-1:0] C_HALF_U   = CNT_W'(UNIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] C_TWO_U    = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] C_TWO_U_M1 = CNT_W'(2 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX_MARK = CNT_W'(4 * UNIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [SYM_W-1:0] C_MAX_SYM  = SYM_W'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_ERR_WAIT
    } state_t;

    // Returns {ok, code} for a symbol count and LSB-aligned pattern.
    function automatic logic [3:0] f_decode(input logic [SYM_W-1:0] cnt,
                                            input logic [PAT_W-1:0] pat);
        case ({cnt, pat})
            7'b010_0001: f_decode = 4'b1_000;
            7'b100_1000: f_decode = 4'b1_001;
            7'b100_1010: f_decode = 4'b1_010;
            7'b011_0100: f_decode = 4'b1_011;
            7'b001_0000: f_decode = 4'b1_100;
            7'b100_0010: f_decode = 4'b1_101;
            7'b011_0110: f_decode = 4'b1_110;
            7'b100_0000: f_decode = 4'b1_111;
            default:     f_decode = 4'b0_000;
        endcase
    endfunction

    logic             r_sync1;
    logic             r_dd_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SYM_W-1:0] r_count;
    logic [PAT_W-1:0] r_pattern;
    logic             r_ovf;
    logic [2:0]       r_letter;
    logic             r_letter_valid;
    logic             r_decode_error;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [SYM_W-1:0] w_count_nxt;
    logic [PAT_W-1:0] w_pattern_nxt;
    logic             w_ovf_nxt;
    logic [2:0]       w_letter_nxt;
    logic             w_valid_nxt;
    logic             w_error_nxt;
    logic             w_is_dash;
    logic [3:0]       w_decode;

    assign w_cnt_inc = (r_cnt == C_CNT_SAT) ? r_cnt : r_cnt + C_CNT_ONE;
    assign w_is_dash = (r_cnt >= C_TWO_U);
    assign w_decode  = f_decode(r_count, r_pattern);

    // Two-flop synchronizer for the asynchronous line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_dd_s  <= 1'b0;
        end else begin
            r_sync1 <= dot_dash_in;
            r_dd_s  <= r_sync1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_count        <= '0;
            r_pattern      <= '0;
            r_ovf          <= 1'b0;
            r_letter       <= 3'b000;
            r_letter_valid <= 1'b0;
            r_decode_error <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_count        <= w_count_nxt;
            r_pattern      <= w_pattern_nxt;
            r_ovf          <= w_ovf_nxt;
            r_letter       <= w_letter_nxt;
            r_letter_valid <= w_valid_nxt;
            r_decode_error <= w_error_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state, run timing, symbol assembly and decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_cnt_inc;
        w_count_nxt   = r_count;
        w_pattern_nxt = r_pattern;
        w_ovf_nxt     = r_ovf;
        w_letter_nxt  = r_letter;
        w_valid_nxt   = 1'b0;
        w_error_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_dd_s) begin
                    w_state_nxt = S_MARK;
                end
            end
            S_MARK: begin
                if (!r_dd_s) begin
                    if (r_cnt < C_HALF_U) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_ERR_WAIT;
                    end else begin
                        if (r_count == C_MAX_SYM) begin
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_pattern_nxt = {r_pattern[PAT_W-2:0], w_is_dash};
                            w_count_nxt   = r_count + SYM_W'(1);
                        end
                        w_state_nxt = S_SPACE;
                    end
                end else if (r_cnt >= C_MAX_MARK) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_ERR_WAIT;
                end
            end
            S_SPACE: begin
                if (r_cnt >= C_TWO_U) begin
                    if (w_decode[3] && !r_ovf) begin
                        w_letter_nxt = w_decode[2:0];
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_ERR_WAIT;
                    end
                end else if (r_dd_s) begin
                    w_state_nxt = S_MARK;
                end
            end
            S_ERR_WAIT: begin
                // r_cnt counts quiet cycles beyond the first; any mark restarts it.
                if (r_dd_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt >= C_TWO_U_M1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = C_CNT_ONE;
        end
        if (w_state_nxt == S_IDLE) begin
            w_count_nxt   = '0;
            w_pattern_nxt = '0;
            w_ovf_nxt     = 1'b0;
        end
    end

    assign letter       = r_letter;
    assign letter_valid = r_letter_valid;
    assign decode_error = r_decode_error;
    assign busy         = r_busy;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Bench for morse_rx_decoder with UNIT_CYCLES=4: randomized mark/space timing
// checked against a symbol-string reference decoder.
module tb_morse_rx_decoder;

    localparam int unsigned U = 4;

    logic       clock       = 1'b0;
    logic       reset_n     = 1'b1;
    logic       dot_dash_in = 1'b0;
    logic [2:0] letter;
    logic       letter_valid;
    logic       decode_error;
    logic       busy;

    morse_rx_decoder #(.UNIT_CYCLES(U), .CNT_W(12)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .dot_dash_in  (dot_dash_in),
        .letter       (letter),
        .letter_valid (letter_valid),
        .decode_error (decode_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int         checks   = 0;
    int         failures = 0;
    int         n_valid  = 0;
    int         n_err    = 0;
    int         n_both   = 0;
    logic [2:0] vq[$];
    logic [2:0] exp_letter = 3'b000;
    int         tb_mark[8];
    int         tb_gap[8];
    string      codes[8];

    // Output monitor, sampled away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (letter_valid) begin
                n_valid <= n_valid + 1;
                vq.push_back(letter);
            end
            if (decode_error) n_err <= n_err + 1;
            if (letter_valid && decode_error) n_both <= n_both + 1;
        end
    end

    task automatic drive(input logic v, input int cyc);
        dot_dash_in = v;
        repeat (cyc) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_arrays(input int n, input int endgap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, tb_mark[i]);
            if (i < n - 1) drive(1'b0, tb_gap[i]);
        end
        drive(1'b0, endgap);
    endtask

    task automatic set_char(input string s, output int n);
        n = s.len();
        for (int i = 0; i < n; i++) begin
            if (s[i] == "-") tb_mark[i] = int'($urandom_range(16, 8));
            else             tb_mark[i] = int'($urandom_range(7, 2));
            tb_gap[i] = int'($urandom_range(7, 1));
        end
    endtask

    // Reference: classify marks by unit thresholds, then look up the string.
    function automatic int model_decode(input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) begin
            if (tb_mark[i] < int'(U / 2) || tb_mark[i] > int'(4 * U + 1)) return -1;
            if (tb_mark[i] >= int'(2 * U)) s = {s, "-"};
            else                           s = {s, "."};
        end
        if (n > 4) return -1;
        for (int c = 0; c < 8; c++) if (s == codes[c]) return c;
        return -1;
    endfunction

    task automatic test_reset;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks += 4;
        if (letter !== 3'b000) begin failures++; $display("FAIL reset_letter got=%0d want=0", letter); end
        if (letter_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", letter_valid); end
        if (decode_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", decode_error); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        drive(1'b0, 4);
    endtask

    task automatic test_latency;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 12);
        dot_dash_in = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        checks += 2;
        if (letter_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b want=0", letter_valid); end
        if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy_before got=%b want=1", busy); end
        @(posedge clock);
        @(negedge clock);
        checks += 3;
        if (letter_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b want=1", letter_valid); end
        if (letter !== 3'b000) begin failures++; $display("FAIL lat_letter got=%0d want=0", letter); end
        if (busy !== 1'b0) begin failures++; $display("FAIL lat_busy_after got=%b want=0", busy); end
        @(posedge clock); #1;
        drive(1'b0, 6);
        checks += 2;
        if (n_valid - v0 != 1) begin failures++; $display("FAIL lat_pulses got=%0d want=1", n_valid - v0); end
        if (n_err != e0) begin failures++; $display("FAIL lat_errors got=%0d want=0", n_err - e0); end
        exp_letter = 3'b000;
    endtask

    task automatic test_all_letters;
        int n, v0, e0;
        for (int c = 0; c < 8; c++) begin
            v0 = n_valid; e0 = n_err;
            set_char(codes[c], n);
            send_arrays(n, int'($urandom_range(12, 8)));
            drive(1'b0, 4);
            checks += 3;
            if (n_valid - v0 != 1) begin failures++; $display("FAIL letters_pulse c=%0d got=%0d want=1", c, n_valid - v0); end
            if (n_err != e0) begin failures++; $display("FAIL letters_error c=%0d got=%0d want=0", c, n_err - e0); end
            if (letter !== 3'(c)) begin failures++; $display("FAIL letters_code got=%0d want=%0d", letter, c); end
            exp_letter = 3'(c);
        end
    endtask

    task automatic test_errors;
        int n, v0, e0;
        v0 = n_valid; e0 = n_err;
        drive(1'b1, 1); drive(1'b0, 8);
        checks++;
        if (n_err - e0 != 1) begin failures++; $display("FAIL err_short got=%0d want=1", n_err - e0); end
        drive(1'b1, 22);
        checks++;
        // Error must already be out while the line is still high.
        if (n_err - e0 != 2) begin failures++; $display("FAIL err_long_mark got=%0d want=2", n_err - e0); end
        drive(1'b0, 8);
        set_char(".", n);
        send_arrays(n, 12);
        checks += 3;
        if (n_valid - v0 != 1) begin failures++; $display("FAIL err_recover_pulse got=%0d want=1", n_valid - v0); end
        if (letter !== 3'b100) begin failures++; $display("FAIL err_recover_code got=%0d want=4", letter); end
        if (n_err - e0 != 2) begin failures++; $display("FAIL err_recover_errs got=%0d want=2", n_err - e0); end
        exp_letter = 3'b100;
    endtask

    task automatic test_overflow;
        int n, v0, e0;
        v0 = n_valid; e0 = n_err;
        set_char(".....", n);
        send_arrays(n, 20);
        checks += 3;
        if (n_err - e0 != 1) begin failures++; $display("FAIL ovf_error got=%0d want=1", n_err - e0); end
        if (n_valid != v0) begin failures++; $display("FAIL ovf_valid got=%0d want=0", n_valid - v0); end
        if (letter !== exp_letter) begin failures++; $display("FAIL ovf_letter got=%0d want=%0d", letter, exp_letter); end
    endtask

    task automatic test_boundaries;
        int bm0[5], bm1[5], bm2[5], bn[5], bg[5], bexp[5], berr[5];
        int v0, e0;
        bm0 = '{2, 7, 8, 4, 4};
        bm1 = '{12, 12, 16, 12, 12};
        bm2 = '{0, 0, 4, 0, 0};
        bn  = '{2, 2, 3, 2, 2};
        bg  = '{4, 4, 4, 7, 8};
        bexp = '{0, 0, 6, 0, 4};
        berr = '{0, 0, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            v0 = n_valid; e0 = n_err;
            tb_mark[0] = bm0[k]; tb_mark[1] = bm1[k]; tb_mark[2] = bm2[k];
            tb_gap[0] = bg[k]; tb_gap[1] = bg[k];
            send_arrays(bn[k], 20);
            checks += 3;
            if (n_valid - v0 != 1) begin failures++; $display("FAIL bnd_pulse k=%0d got=%0d want=1", k, n_valid - v0); end
            if (letter !== 3'(bexp[k])) begin failures++; $display("FAIL bnd_code k=%0d got=%0d want=%0d", k, letter, bexp[k]); end
            if (n_err - e0 != berr[k]) begin failures++; $display("FAIL bnd_error k=%0d got=%0d want=%0d", k, n_err - e0, berr[k]); end
            exp_letter = 3'(bexp[k]);
        end
    endtask

    task automatic test_random;
        int n, v0, e0, e;
        string s;
        for (int it = 0; it < 12; it++) begin
            s = "";
            n = int'($urandom_range(5, 1));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(1, 0) == 1) s = {s, "-"};
                else                           s = {s, "."};
            end
            set_char(s, n);
            e = model_decode(n);
            v0 = n_valid; e0 = n_err;
            send_arrays(n, 20);
            checks += 3;
            if (e < 0) begin
                if (n_err - e0 != 1) begin failures++; $display("FAIL rand_error s=%s got=%0d want=1", s, n_err - e0); end
                if (n_valid != v0) begin failures++; $display("FAIL rand_valid s=%s got=%0d want=0", s, n_valid - v0); end
                if (letter !== exp_letter) begin failures++; $display("FAIL rand_hold s=%s got=%0d want=%0d", s, letter, exp_letter); end
            end else begin
                if (n_valid - v0 != 1) begin failures++; $display("FAIL rand_pulse s=%s got=%0d want=1", s, n_valid - v0); end
                if (n_err != e0) begin failures++; $display("FAIL rand_noerr s=%s got=%0d want=0", s, n_err - e0); end
                if (letter !== 3'(e)) begin failures++; $display("FAIL rand_code s=%s got=%0d want=%0d", s, letter, e); end
                exp_letter = 3'(e);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n, s0, e0;
        s0 = vq.size(); e0 = n_err;
        set_char(".", n);  send_arrays(n, 8);
        set_char(".-", n); send_arrays(n, 8);
        set_char(".", n);  send_arrays(n, 8);
        drive(1'b0, 12);
        checks += 2;
        if (vq.size() - s0 != 3) begin
            failures++; $display("FAIL b2b_count got=%0d want=3", vq.size() - s0);
        end else begin
            checks += 3;
            if (vq[s0] !== 3'b100) begin failures++; $display("FAIL b2b_first got=%0d want=4", vq[s0]); end
            if (vq[s0+1] !== 3'b000) begin failures++; $display("FAIL b2b_second got=%0d want=0", vq[s0+1]); end
            if (vq[s0+2] !== 3'b100) begin failures++; $display("FAIL b2b_third got=%0d want=4", vq[s0+2]); end
        end
        if (n_err != e0) begin failures++; $display("FAIL b2b_errors got=%0d want=0", n_err - e0); end
        exp_letter = 3'b100;
    endtask

    task automatic test_reset_mid;
        int n, v0, e0;
        drive(1'b1, 12); drive(1'b0, 4); drive(1'b1, 3);
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (letter !== 3'b000) begin failures++; $display("FAIL rstmid_letter got=%0d want=0", letter); end
        if (letter_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", letter_valid); end
        if (decode_error !== 1'b0) begin failures++; $display("FAIL rstmid_error got=%b want=0", decode_error); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        dot_dash_in = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        reset_n = 1'b1;
        drive(1'b0, 4);
        v0 = n_valid; e0 = n_err;
        set_char(".", n);
        send_arrays(n, 12);
        checks += 3;
        if (n_valid - v0 != 1) begin failures++; $display("FAIL rstmid_pulse got=%0d want=1", n_valid - v0); end
        if (letter !== 3'b100) begin failures++; $display("FAIL rstmid_code got=%0d want=4", letter); end
        if (n_err != e0) begin failures++; $display("FAIL rstmid_noerr got=%0d want=0", n_err - e0); end
    endtask

    initial begin
        codes[0] = ".-";   codes[1] = "-..."; codes[2] = "-.-."; codes[3] = "-..";
        codes[4] = ".";    codes[5] = "..-."; codes[6] = "--.";  codes[7] = "....";
        test_reset();
        test_latency();
        test_all_letters();
        test_errors();
        test_overflow();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (n_both != 0) begin failures++; $display("FAIL pulse_overlap got=%0d want=0", n_both); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_rx_decoder.md
Name: morse_rx_decoder

Overview:
- Downstream receiver for the 3-bit-letter Morse transmitter: consumes its serial dot/dash line, which is high for a mark and low for a space.
- Measures mark and space run lengths in clock cycles against a unit time.
- Assembles up to 4 dot/dash symbols and decodes the pattern back to the 3-bit letter code A..H (000..111).
- Reports one decoded letter or one error per received character.

Parameters:
- UNIT_CYCLES, 250, clock cycles per Morse unit. Matches the transmitter divider reload of 249.
- CNT_W, 12, run-length counter width. Must hold 4*UNIT_CYCLES+1.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- dot_dash_in  input  1  serial Morse line, asynchronous to decode timing
- letter  output  3  last decoded letter code, 000=A .. 111=H
- letter_valid  output  1  one-cycle pulse; letter updated this cycle
- decode_error  output  1  one-cycle pulse; malformed character received
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: letter=000, letter_valid=0, decode_error=0, busy=0, FSM=IDLE, symbol count=0, pattern=0, overflow flag=0, run counter=0.
- Input sync: 2-flop synchronizer; dd_s lags dot_dash_in by 2 clocks. The FSM uses only dd_s.
- Run counter: reloads to 1 on each FSM state entry. Increments by 1 per cycle and saturates at all-ones.
- U = UNIT_CYCLES.
- IDLE:
  - dd_s=1 -> MARK.
  - Symbol count, pattern and overflow flag are cleared on entry to IDLE.
- MARK, with L = run count at the falling dd_s:
  - L < U/2 (integer divide) -> error.
  - U/2 <= L < 2U -> dot: shift 0 into pattern.
  - L >= 2U -> dash: shift 1 into pattern.
  - Pattern shifts in at the LSB; 4 bits wide.
  - After the shift, count = count+1. If count was already 4, set overflow and leave pattern and count unchanged.
  - Then go to SPACE.
  - If the run count reaches 4U+1 while dd_s=1 -> error immediately, without waiting for the falling edge.
- SPACE:
  - dd_s=1 with run count < 2U -> MARK (intra-character gap).
  - Run count reaching 2U -> end of character: decode, then go to IDLE. No later mark is needed.
- Decode table (count:pattern):
  - 2:01 -> A=000
  - 4:1000 -> B=001
  - 4:1010 -> C=010
  - 3:100 -> D=011
  - 1:0 -> E=100
  - 4:0010 -> F=101
  - 3:110 -> G=110
  - 4:0000 -> H=111
  - Any other combination, or overflow set -> error.
- Success: letter loads the code and letter_valid pulses 1 cycle, both registered together.
- Error: decode_error pulses 1 cycle; letter holds its previous value; FSM -> ERR_WAIT.
- ERR_WAIT: wait for dd_s=0 continuously for 2U cycles (any high restarts the wait), then -> IDLE. No pulses are generated in ERR_WAIT.
- Latency: letter_valid is high in the cycle after clock edge n+2U+2, where edge n is the first edge that samples dot_dash_in low after the character's final mark.
- Transmitter repeats the character (rotating pattern): each repetition is decoded and pulsed independently.
- letter_valid and decode_error are never high together.
- At most one pulse per character.
- reset_n low at any time: immediate return to reset state, with any partially received symbols discarded.

Test Plan:
1. UNIT_CYCLES=4; drive the transmitter A waveform (mark 4, space 4, mark 12, space >=8) -> letter=000 and one letter_valid pulse exactly 2U+2=10 edges after the line falls; busy returns to 0 the same cycle.
2. Feed all 8 transmitter patterns, from the transmitter model or a directly generated waveform -> letters 000..111 in order, with no decode_error.
3. Marks of 1 cycle, then a 5-unit mark -> decode_error pulse for each. The 5-unit error fires at run count 17 while the line is still high. No letter_valid; the next valid character decodes correctly after an 8-cycle low.
4. Five dots (.....) -> overflow -> one decode_error at end of character; letter unchanged from its prior value.
5. Mark-length boundaries with U=4: 2-cycle mark = dot, 7-cycle = dot, 8-cycle = dash, 16-cycle = dash. Space boundaries: 7-cycle space continues the character; 8-cycle space ends it.
6. Assert reset_n mid-character (after dash of B) -> all outputs 0 asynchronously. A subsequent full E decodes to 100 with no error.
